win_framer: RTL

Overlapping frame builder directly upstream of the `win` windowing stage. Accepts a continuous complex sample stream and emits frames of `Nwin` samples with 50 % overlap. Each frame is a gapless burst tagged with `index` 0..Nwin-1, so `dv_out`, `index`, `dout_real` and `dout_imag` connect straight to `win`'s `dv_in`, `index`, `din_real` and `din_imag`. Readout runs at full clock rate, so input duty must be ≤ 50 %.

---
 rtl/win_framer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/win_framer.sv
// Overlapping frame builder: buffers a complex sample stream and replays
// Nwin-sample frames with 50% overlap as gapless, index-tagged bursts.
module win_framer #(
    parameter int Dwidth = 16,
    parameter int Nwin   = 32,
    parameter int Iwidth = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dv_in,
    input  logic [Dwidth-1:0] din_real,
    input  logic [Dwidth-1:0] din_imag,
    output logic              dv_out,
    output logic [Iwidth-1:0] index,
    output logic [Dwidth-1:0] dout_real,
    output logic [Dwidth-1:0] dout_imag,
    output logic              overflow
);

    localparam int AW    = Iwidth + 1;
    localparam int DEPTH = 2 * Nwin;
    localparam int HALF  = Nwin / 2;
    localparam int HW    = Iwidth - 1;

    typedef struct packed {
        logic [Dwidth-1:0] re;
        logic [Dwidth-1:0] im;
    } samp_t;

    typedef enum logic {IDLE, READ} state_t;

    samp_t             mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [HW-1:0]     hcnt;
    logic              primed;

    state_t            state, nxt_state;
    logic [Iwidth-1:0] rcnt, nxt_rcnt;
    logic [AW-1:0]     start, nxt_start;
    logic              pend_vld, nxt_pend_vld;
    logic [AW-1:0]     pend_addr, nxt_pend_addr;
    logic              drop;

    logic              frame_rdy;
    logic [AW-1:0]     rdy_addr;
    logic [AW-1:0]     raddr;
    logic              rd_last;

    // The sample that fills the first Nwin slots counts as primed for its own frame.
    assign frame_rdy = dv_in && (hcnt == HW'(HALF - 1)) &&
                       (primed || (wptr == AW'(Nwin - 1)));
    // (wptr + 1) - Nwin is the same as (wptr + 1) + Nwin modulo 2*Nwin.
    assign rdy_addr  = wptr + AW'(Nwin + 1);
    assign raddr     = start + {1'b0, rcnt};
    assign rd_last   = (rcnt == Iwidth'(Nwin - 1));

    // Sample storage has no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (dv_in)
            mem[wptr] <= '{re: din_real, im: din_imag};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr   <= '0;
            hcnt   <= '0;
            primed <= 1'b0;
        end else if (dv_in) begin
            wptr <= wptr + 1'b1;
            hcnt <= hcnt + 1'b1;
            if (wptr == AW'(Nwin - 1))
                primed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rcnt      <= '0;
            start     <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= nxt_state;
            rcnt      <= nxt_rcnt;
            start     <= nxt_start;
            pend_vld  <= nxt_pend_vld;
            pend_addr <= nxt_pend_addr;
            if (drop)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_rcnt      = rcnt;
        nxt_start     = start;
        nxt_pend_vld  = pend_vld;
        nxt_pend_addr = pend_addr;
        drop          = 1'b0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    nxt_state     = READ;
                    nxt_start     = pend_addr;
                    nxt_rcnt      = '0;
                    nxt_pend_vld  = frame_rdy;
                    nxt_pend_addr = rdy_addr;
                end else if (frame_rdy) begin
                    nxt_state = READ;
                    nxt_start = rdy_addr;
                    nxt_rcnt  = '0;
                end
            end
            READ: begin
                nxt_rcnt = rcnt + 1'b1;
                if (rd_last) begin
                    // Pending frame goes first; a frame arriving now takes the freed slot.
                    if (pend_vld) begin
                        nxt_start     = pend_addr;
                        nxt_rcnt      = '0;
                        nxt_pend_vld  = frame_rdy;
                        nxt_pend_addr = rdy_addr;
                    end else if (frame_rdy) begin
                        nxt_start = rdy_addr;
                        nxt_rcnt  = '0;
                    end else begin
                        nxt_state = IDLE;
                        nxt_rcnt  = '0;
                    end
                end else if (frame_rdy) begin
                    if (pend_vld) begin
                        drop = 1'b1;
                    end else begin
                        nxt_pend_vld  = 1'b1;
                        nxt_pend_addr = rdy_addr;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // The memory read register doubles as the output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dv_out    <= 1'b0;
            index     <= '0;
            dout_real <= '0;
            dout_imag <= '0;
        end else if (state == READ) begin
            dv_out    <= 1'b1;
            index     <= rcnt;
            dout_real <= mem[raddr].re;
            dout_imag <= mem[raddr].im;
        end else begin
            dv_out <= 1'b0;
        end
    end

endmodule
